instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Parametrised fetch stage: a program counter drives a synchronous-read instruction RAM, and a small prefetch queue holds the fetched {pc, instruction} pairs. Stalls hold the queue head without dropping instructions already in flight. A redirect (branch or flush) discards stale fetches in one cycle. The block sits at the head of the pipeline, feeds decode, and also accepts program-load writes.

## Interface
- ADDR_W, 9: RAM index width; RAM holds 2^ADDR_W half-words.
- QUEUE_DEPTH, 4: prefetch entries, minimum 2, power of two.
- RESET_PC, 32'h0: PC after reset.
- PC_STEP, 2: byte increment per fetch.
- clk_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- program_mem_write_en_i  in  1  load mode; writes instruction_i at write_addr_i.
- write_addr_i  in  WORD  byte address of the write; RAM index = write_addr_i[ADDR_W:1].
- instruction_i  in  HALF_WORD  write data.
- redirect_valid_i  in  1  branch or flush request.
- redirect_addr_i  in  WORD  new PC, byte address.
- stall_pipeline_i  in  stall_pipeline_sig  decode stall; head is held while it is active.
- is_valid_o  out  1  queue head is valid.
- instruction_o  out  HALF_WORD  head instruction.
- program_counter_o  out  WORD  PC of the head instruction.

## Operation
- **Fetch PC (fetch_pc):**
  - Read index = fetch_pc[ADDR_W:1].
  - Advances by PC_STEP on each issued read and wraps modulo 2^32.
  - The RAM index wraps modulo 2^ADDR_W.
- **Issue rule.** A read is issued in a cycle only if all of these hold:
  - no reset, no load, no redirect;
  - count + inflight − pop < QUEUE_DEPTH, where inflight ∈ {0,1} and pop = is_valid_o && !stall.
- **Return.** Read data returns the next cycle and is pushed with its PC, unless the epoch has changed since issue.
- **Epoch.** A 1-bit epoch toggles on every redirect or load cycle. Returns tagged with the old epoch are dropped.
- **Pop.** When is_valid_o is high and stall is inactive, the head pops at the clock edge. Push and pop can occur in the same cycle and leave count unchanged.
- **Redirect** (redirect_valid_i high in cycle N):
  - queue cleared and in-flight read squashed at edge N+1;
  - fetch_pc ← redirect_addr_i;
  - no read issued in cycle N.
  - Redirect beats stall and beats pop.
- **Load mode** (program_mem_write_en_i high):
  - the RAM port performs the write;
  - the queue is cleared, no fetch is issued, and fetch_pc ← RESET_PC.
  - Fetching resumes the first cycle after write_en falls.
  - Load beats redirect.
- **Priority:** reset > load > redirect > stall > normal fetch.
- **Reset:** fetch_pc = RESET_PC; count = 0; inflight = 0; epoch = 0.

## Timing
- **Output reset values:** is_valid_o = 0, instruction_o = 0, program_counter_o = RESET_PC.
  - Outputs come from registered queue storage.
  - While is_valid_o is low, instruction_o and program_counter_o are held at their last values, or at 0 / RESET_PC after reset.
- **Latency from issue to head:** 2 cycles. A read issued in cycle C is visible on the outputs in cycle C+2 if the queue was empty. No bypass.
- **Startup:** reset deasserted before cycle 0 → first issue in cycle 0 → is_valid_o = 1 in cycle 2 with program_counter_o = RESET_PC.
- **Throughput:** one instruction per cycle sustained with no stall for any QUEUE_DEPTH ≥ 2.
- **Redirect:** redirect in cycle N → is_valid_o = 0 from N+1 → first new instruction valid at N+3.
- **Full queue:** issue stops. The only possible in-flight read was accounted for by the credit rule, so overflow cannot occur. An assertion flags a push when count == QUEUE_DEPTH.
- **Empty queue:** is_valid_o = 0 and stall has no effect.
- **Mid-operation reset:** in-flight data is discarded, and all state returns to reset values at the next edge.

## Structure
- **Shared package (GENERAL_DEFS):** WORD, HALF_WORD, stall_pipeline_sig with STALL_PIPELINE, and flush_pipeline_sig. Redirect sources use FLUSH_PIPELINE upstream.
- **Sub-module fetch_queue:** parametrised circular buffer over {WORD pc, HALF_WORD instr}, with push/pop/clear, count, and head outputs.
- **RAM:** the existing instruction_ram, or the DC macro, under the same `ifdef` selection. The top level contains the PC, issue/credit logic and epoch.

## Test plan
- **Reset then run:** RAM[0..3] = 0x1111, 0x2222, 0x3333, 0x4444 → is_valid_o rises in cycle 2 with (pc, instr) = (0, 0x1111), then (2, 0x2222), (4, 0x3333), (6, 0x4444) on consecutive cycles.
- **Stall:** stall for 5 cycles while the head is pc 2 → outputs held at (2, 0x2222), no loss or duplication, count ≤ QUEUE_DEPTH. After release, pc 4 appears the next cycle.
- **Redirect during in-flight read:** redirect_addr = 0x20 → is_valid_o = 0 for 2 cycles, next valid is (0x20, RAM[16]), and no stale pc appears.
- **Load mode:** write 0xBEEF at address 0x0 while fetching → queue cleared; after write_en falls, the first valid is (RESET_PC, 0xBEEF).
- **Wrap:** fetch_pc = 2^(ADDR_W+1) − 2 → next RAM index is 0 and program_counter_o continues unwrapped.
- **Simultaneous events:** stall + redirect in the same cycle, and load + redirect in the same cycle → the priority order holds. Reset asserted with a full queue → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// rtl/instruction_fetch_queue_pkg.sv - shared fetch-stage types
// Purpose: word/half-word types, pipeline control enums and the queue entry
// layout shared by the fetch top level, its prefetch queue and the bench.
package instruction_fetch_queue_pkg;

    typedef logic [31:0] WORD;
    typedef logic [15:0] HALF_WORD;

    typedef enum logic {
        NO_STALL       = 1'b0,
        STALL_PIPELINE = 1'b1
    } stall_pipeline_sig;

    // Upstream redirect sources raise FLUSH_PIPELINE; the fetch stage only
    // sees the resulting redirect_valid_i.
    typedef enum logic {
        NO_FLUSH       = 1'b0,
        FLUSH_PIPELINE = 1'b1
    } flush_pipeline_sig;

    typedef struct packed {
        WORD      pc;
        HALF_WORD instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_queue.sv
// rtl/instruction_fetch_queue_queue.sv - circular prefetch buffer of {pc, instr}
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   clear_i               drop all entries (head registers keep their value)
//   push_i, push_data_i   append one entry
//   pop_i                 remove the head entry (ignored when empty)
//   count_o               number of stored entries
//   head_o                registered copy of the head entry
module fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter WORD RESET_PC = 32'h0,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    fetch_entry_t           head_q;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && !clear_i && (count != '0);

    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '{pc: RESET_PC, instr: '0};
        end else if (clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            // The head registers track whatever entry will be at the head
            // next cycle; when the queue drains they simply keep the old value.
            if (do_pop && count > CNT_ONE) begin
                head_q <= mem[rd_ptr + PTR_ONE];
            end else if (do_push && (count == '0 || (do_pop && count == CNT_ONE))) begin
                head_q <= push_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && do_push) begin
            assert (count < CNT_W'(DEPTH) || do_pop)
                else $error("fetch_queue push while full");
        end
    end
`endif

    assign count_o = count;
    assign head_o  = head_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC, instruction RAM, credit-based prefetch queue
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   program_mem_write_en_i      load mode: write instruction_i at write_addr_i
//   write_addr_i, instruction_i load address (byte) and data
//   redirect_valid_i/addr_i     branch or flush to a new byte PC
//   stall_pipeline_i            decode stall, holds the queue head
//   is_valid_o, instruction_o, program_counter_o   queue head to decode
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int  ADDR_W      = 9,
    parameter int  QUEUE_DEPTH = 4,
    parameter WORD RESET_PC    = 32'h0,
    parameter int  PC_STEP     = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              program_mem_write_en_i,
    input  WORD               write_addr_i,
    input  HALF_WORD          instruction_i,
    input  logic              redirect_valid_i,
    input  WORD               redirect_addr_i,
    input  stall_pipeline_sig stall_pipeline_i,
    output logic              is_valid_o,
    output HALF_WORD          instruction_o,
    output WORD               program_counter_o
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    WORD              fetch_pc;
    WORD              inflight_pc;
    logic             inflight;
    logic             inflight_epoch;
    logic             epoch;
    HALF_WORD         ram_rdata;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic             load;
    logic             redirect;
    logic             pop;
    logic             issue;
    logic             push;
    logic             clear;
    fetch_entry_t     head;
    logic             unused_addr_bits;

    assign load     = program_mem_write_en_i;
    assign redirect = redirect_valid_i && !load;
    assign clear    = load || redirect_valid_i;

    assign is_valid_o        = (count != '0);
    assign pop               = is_valid_o && (stall_pipeline_i != STALL_PIPELINE) && !clear;

    // Slots committed after this edge: stored entries plus the outstanding
    // read, minus the one leaving. Issuing only below QUEUE_DEPTH means every
    // return always has a slot, so a stall never has to drop data.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = !reset_i && !clear && (occupancy < OCC_W'(QUEUE_DEPTH));

    // A return issued under an older epoch belongs to a discarded path.
    assign push = inflight && (inflight_epoch == epoch) && !clear;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else begin
            if (load) begin
                fetch_pc <= RESET_PC;
            end else if (redirect) begin
                fetch_pc <= redirect_addr_i;
            end else if (issue) begin
                fetch_pc <= fetch_pc + WORD'(PC_STEP);
            end
            if (clear) begin
                epoch <= ~epoch;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
            end
        end
    end

`ifdef INSTR_RAM_DC_MACRO
    instruction_ram_dc #(
        .ADDR_W (ADDR_W)
    ) u_instr_ram (
        .clk_i   (clk_i),
        .we_i    (load),
        .re_i    (issue),
        .waddr_i (write_addr_i[ADDR_W:1]),
        .raddr_i (fetch_pc[ADDR_W:1]),
        .wdata_i (instruction_i),
        .rdata_o (ram_rdata)
    );
`else
    HALF_WORD ram [2**ADDR_W];

    // Single port: a load cycle writes, otherwise an issued fetch reads.
    always_ff @(posedge clk_i) begin
        if (load) begin
            ram[write_addr_i[ADDR_W:1]] <= instruction_i;
        end else if (issue) begin
            ram_rdata <= ram[fetch_pc[ADDR_W:1]];
        end
    end
`endif

    assign unused_addr_bits = ^{write_addr_i[31:ADDR_W+1], write_addr_i[0]};

    fetch_queue #(
        .DEPTH    (QUEUE_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fetch_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i ('{pc: inflight_pc, instr: ram_rdata}),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign instruction_o     = head.instr;
    assign program_counter_o = head.pc;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              write_en;
    WORD               write_addr;
    HALF_WORD          write_data;
    logic              redirect;
    WORD               redirect_addr;
    stall_pipeline_sig stall;
    logic              is_valid;
    HALF_WORD          instr;
    WORD               pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .ADDR_W      (9),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0),
        .PC_STEP     (2)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .program_mem_write_en_i (write_en),
        .write_addr_i           (write_addr),
        .instruction_i          (write_data),
        .redirect_valid_i       (redirect),
        .redirect_addr_i        (redirect_addr),
        .stall_pipeline_i       (stall),
        .is_valid_o             (is_valid),
        .instruction_o          (instr),
        .program_counter_o      (pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic v, input WORD epc, input HALF_WORD ein);
        chk({tag, ".valid"}, 32'(is_valid), 32'(v));
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".instr"}, 32'(instr), 32'(ein));
    endtask

    task automatic load_word(input WORD addr, input HALF_WORD data);
        write_en   = 1'b1;
        write_addr = addr;
        write_data = data;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        write_en      = 1'b0;
        write_addr    = '0;
        write_data    = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        stall         = NO_STALL;
        step();
        step();
        expect_head("reset", 1'b0, 32'h0, 16'h0);

        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load_word(WORD'(2 * i), HALF_WORD'(16'h1111 * (i + 1)));
        end
        load_word(32'h20, 16'hA016);
        load_word(32'h22, 16'hA017);
        load_word(32'h3FE, 16'hB1FF);
        write_en = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;

        // cycle 0: first issue; head appears in cycle 2
        chk("c0.valid", 32'(is_valid), 32'h0);
        step();
        chk("c1.valid", 32'(is_valid), 32'h0);
        step();
        expect_head("c2", 1'b1, 32'h0, 16'h1111);
        step();
        expect_head("c3", 1'b1, 32'h2, 16'h2222);
        stall = STALL_PIPELINE;
        for (int k = 4; k <= 8; k++) begin
            step();
            expect_head($sformatf("stall%0d", k), 1'b1, 32'h2, 16'h2222);
            if (k == 8) stall = NO_STALL;
        end
        step();
        expect_head("c9", 1'b1, 32'h4, 16'h3333);
        step();
        expect_head("c10", 1'b1, 32'h6, 16'h4444);
        step();
        expect_head("c11", 1'b1, 32'h8, 16'h5555);
        redirect      = 1'b1;
        redirect_addr = 32'h20;
        step();
        redirect = 1'b0;
        expect_head("redir_n1", 1'b0, 32'h8, 16'h5555);
        step();
        chk("redir_n2.valid", 32'(is_valid), 32'h0);
        step();
        expect_head("redir_n3", 1'b1, 32'h20, 16'hA016);
        step();
        expect_head("redir_n4", 1'b1, 32'h22, 16'hA017);

        // stall and redirect together: redirect wins
        stall         = STALL_PIPELINE;
        redirect      = 1'b1;
        redirect_addr = 32'h3FE;
        step();
        stall    = NO_STALL;
        redirect = 1'b0;
        expect_head("sr_n1", 1'b0, 32'h22, 16'hA017);
        step();
        chk("sr_n2.valid", 32'(is_valid), 32'h0);
        step();
        expect_head("wrap_last", 1'b1, 32'h3FE, 16'hB1FF);
        step();
        expect_head("wrap_idx0", 1'b1, 32'h400, 16'h1111);
        step();
        expect_head("wrap_idx1", 1'b1, 32'h402, 16'h2222);

        // load and redirect together: load wins, restart at RESET_PC
        write_en      = 1'b1;
        write_addr    = 32'h0;
        write_data    = 16'hBEEF;
        redirect      = 1'b1;
        redirect_addr = 32'h20;
        step();
        write_en = 1'b0;
        redirect = 1'b0;
        chk("load_n1.valid", 32'(is_valid), 32'h0);
        step();
        chk("load_n2.valid", 32'(is_valid), 32'h0);
        step();
        expect_head("load_n3", 1'b1, 32'h0, 16'hBEEF);
        step();
        expect_head("load_n4", 1'b1, 32'h2, 16'h2222);

        // fill the queue under stall, then reset
        stall = STALL_PIPELINE;
        for (int k = 0; k < 6; k++) begin
            step();
            expect_head($sformatf("fill%0d", k), 1'b1, 32'h2, 16'h2222);
        end
        reset = 1'b1;
        step();
        expect_head("reset_full", 1'b0, 32'h0, 16'h0);
        reset = 1'b0;
        stall = NO_STALL;
        step();
        chk("post_reset_c1.valid", 32'(is_valid), 32'h0);
        step();
        expect_head("post_reset_c2", 1'b1, 32'h0, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
